// File: rtl/button_debouncer.sv
// Paddle push-button conditioner: 2-FF synchroniser feeding a counter-qualified debounce FSM.
// Produces a debounced level, press/release/long-hold pulses and a wrapping press tally.
module button_debouncer #(
    parameter int unsigned STABLE_CNT = 4,
    parameter int unsigned HOLD_CNT   = 8,
    parameter int unsigned CNT_W      = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sample_en,
    input  logic       pb,
    output logic       pb_state,
    output logic       pb_down,
    output logic       pb_up,
    output logic       pb_hold,
    output logic [7:0] press_count
);

    typedef enum logic [1:0] {StUp, StChkDn, StDown, StChkUp} state_e;

    state_e           state_q, state_d;
    logic             s1_q, s1_d, s2_q, s2_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic             pb_state_q, pb_state_d;
    logic             pb_down_q, pb_down_d;
    logic             pb_up_q, pb_up_d;
    logic             pb_hold_q, pb_hold_d;
    logic [7:0]       press_q, press_d;
    logic             hold_hit;

    localparam logic [CNT_W-1:0] StableLast = CNT_W'(STABLE_CNT - 1);
    localparam logic [CNT_W-1:0] HoldMax    = CNT_W'(HOLD_CNT);

    always_comb begin
        s1_d      = pb;
        s2_d      = s1_q;
        state_d   = state_q;
        cnt_d     = cnt_q;
        hold_d    = hold_q;
        press_d   = press_q;
        hold_hit  = 1'b0;

        if (sample_en) begin
            unique case (state_q)
                StUp: begin
                    if (s2_q) begin
                        if (STABLE_CNT == 1) begin
                            state_d = StDown;
                        end else begin
                            state_d = StChkDn;
                            cnt_d   = CNT_W'(1);
                        end
                    end
                end
                StChkDn: begin
                    if (!s2_q) begin
                        state_d = StUp;
                        cnt_d   = '0;
                    end else if (cnt_q == StableLast) begin
                        state_d = StDown;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                StDown: begin
                    if (!s2_q) begin
                        if (STABLE_CNT == 1) begin
                            state_d = StUp;
                        end else begin
                            state_d = StChkUp;
                            cnt_d   = CNT_W'(1);
                        end
                    end
                end
                StChkUp: begin
                    if (s2_q) begin
                        state_d = StDown;
                        cnt_d   = '0;
                    end else if (cnt_q == StableLast) begin
                        state_d = StUp;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = StUp;
                    cnt_d   = '0;
                end
            endcase

            if ((state_q == StDown || state_q == StChkUp) && hold_q != HoldMax) begin
                hold_d   = hold_q + CNT_W'(1);
                hold_hit = (hold_d == HoldMax);
            end
        end

        pb_state_d = (state_d == StDown) || (state_d == StChkUp);
        pb_down_d  = pb_state_d && !pb_state_q;
        pb_up_d    = !pb_state_d && pb_state_q;
        // A hold reaching its limit on the very sample that releases is dropped.
        pb_hold_d  = hold_hit && pb_state_d;
        if (!pb_state_d) begin
            hold_d = '0;
        end
        if (pb_down_d) begin
            press_d = press_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            state_q    <= StUp;
            cnt_q      <= '0;
            hold_q     <= '0;
            pb_state_q <= 1'b0;
            pb_down_q  <= 1'b0;
            pb_up_q    <= 1'b0;
            pb_hold_q  <= 1'b0;
            press_q    <= '0;
        end else begin
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hold_q     <= hold_d;
            pb_state_q <= pb_state_d;
            pb_down_q  <= pb_down_d;
            pb_up_q    <= pb_up_d;
            pb_hold_q  <= pb_hold_d;
            press_q    <= press_d;
        end
    end

    assign pb_state    = pb_state_q;
    assign pb_down     = pb_down_q;
    assign pb_up       = pb_up_q;
    assign pb_hold     = pb_hold_q;
    assign press_count = press_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Scoreboarded bench for button_debouncer: directed presses push expected pulse events,
// a negedge monitor pops and compares them as the DUT pulses.
module tb_button_debouncer;

    localparam int KDn   = 0;
    localparam int KUp   = 1;
    localparam int KHold = 2;

    typedef struct {
        int kind;
        int cyc;
        int cnt;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       sample_en;
    logic       pb;
    logic       pb_state, pb_down, pb_up, pb_hold;
    logic [7:0] press_count;

    int  cyc = 0;
    int  total = 0;
    int  bad = 0;
    bit  sparse = 1'b0;
    ev_t sb[$];

    button_debouncer #(
        .STABLE_CNT(4),
        .HOLD_CNT  (8),
        .CNT_W     (8)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .sample_en  (sample_en),
        .pb         (pb),
        .pb_state   (pb_state),
        .pb_down    (pb_down),
        .pb_up      (pb_up),
        .pb_hold    (pb_hold),
        .press_count(press_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int kind, input int at, input int cnt);
        ev_t e;
        e.kind = kind;
        e.cyc  = at;
        e.cnt  = cnt;
        sb.push_back(e);
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            sample_en = sparse ? (((cyc + 1) % 4) == 0) : 1'b1;
        end
    endtask

    task automatic mon_one(input int kind);
        ev_t e;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $display("FAIL unexpected_pulse: kind %0d at cyc %0d count %0d, none expected",
                     kind, cyc, press_count);
        end else begin
            e = sb.pop_front();
            if (e.kind != kind || e.cyc != cyc || e.cnt != int'(press_count)) begin
                bad++;
                $display("FAIL pulse_event: got kind %0d cyc %0d count %0d, expected kind %0d cyc %0d count %0d",
                         kind, cyc, press_count, e.kind, e.cyc, e.cnt);
            end
        end
    endtask

    always @(negedge clk) begin
        if (reset && (pb_down || pb_up || pb_hold)) begin
            check("down_up_exclusive", int'(pb_down & pb_up), 0);
            if (pb_down) mon_one(KDn);
            if (pb_up)   mon_one(KUp);
            if (pb_hold) mon_one(KHold);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected finish before time limit");
        $fatal(1);
    end

    initial begin
        int n;
        pb        = 1'b0;
        reset     = 1'b0;
        sample_en = 1'b1;
        tick(3);
        reset = 1'b1;
        tick(1);
        check("reset_state", int'(pb_state), 0);
        check("reset_count", int'(press_count), 0);
        check("reset_pulses", int'({pb_down, pb_up, pb_hold}), 0);

        // Clean press held long enough for a hold pulse, then release.
        n  = cyc;
        pb = 1'b1;
        push(KDn, n + 6, 1);
        push(KHold, n + 14, 1);
        tick(20);
        check("held_state", int'(pb_state), 1);
        check("held_count", int'(press_count), 1);
        n  = cyc;
        pb = 1'b0;
        push(KUp, n + 6, 1);
        tick(10);
        check("released_state", int'(pb_state), 0);
        check("hold_cnt_cleared", int'(u_dut.hold_q), 0);

        // Bounce 1,0,1,0 then steady 1.
        pb = 1'b1; tick(1);
        pb = 1'b0; tick(1);
        pb = 1'b1; tick(1);
        pb = 1'b0; tick(1);
        n  = cyc;
        pb = 1'b1;
        push(KDn, n + 6, 2);
        push(KHold, n + 14, 2);
        tick(16);
        n  = cyc;
        pb = 1'b0;
        push(KUp, n + 6, 2);
        tick(10);

        // Short glitch is rejected.
        pb = 1'b1; tick(3);
        pb = 1'b0; tick(10);
        check("glitch_state", int'(pb_state), 0);
        check("glitch_count", int'(press_count), 2);

        // Sample strobe every 4th clock.
        sparse = 1'b1;
        while ((cyc % 4) != 0) tick(1);
        n  = cyc;
        pb = 1'b1;
        push(KDn, n + 16, 3);
        tick(15);
        check("sparse_not_yet", int'(pb_state), 0);
        tick(1);
        check("sparse_risen", int'(pb_state), 1);
        tick(4);
        pb = 1'b0;
        push(KUp, n + 36, 3);
        tick(20);
        check("sparse_released", int'(pb_state), 0);
        sparse = 1'b0;
        tick(1);

        // Reset while pressed; pb stays high and is debounced again as a first press.
        n  = cyc;
        pb = 1'b1;
        push(KDn, n + 6, 4);
        tick(10);
        check("pre_reset_state", int'(pb_state), 1);
        reset = 1'b0;
        tick(1);
        reset = 1'b1;
        check("mid_reset_state", int'(pb_state), 0);
        check("mid_reset_count", int'(press_count), 0);
        check("mid_reset_pulses", int'({pb_down, pb_up, pb_hold}), 0);
        push(KDn, n + 17, 1);
        tick(7);
        pb = 1'b0;
        push(KUp, n + 24, 1);
        tick(8);
        check("after_reset_count", int'(press_count), 1);

        // 255 further presses wrap the tally back to 0.
        for (int k = 2; k <= 256; k++) begin
            n  = cyc;
            pb = 1'b1;
            push(KDn, n + 6, k % 256);
            tick(6);
            pb = 1'b0;
            push(KUp, n + 12, k % 256);
            tick(8);
        end
        check("wrap_count", int'(press_count), 0);
        tick(5);
        check("scoreboard_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
